// File: rtl/load_store_unit_pkg.sv
// Shared types, RV32I size/sign codes and byte-lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // Size is func3[1:0]: 00 byte, 01 half, anything else is treated as a word.
    function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [BE_W-1:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            default: bad = (lane != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data memory port: req/gnt/rvalid handshake with byte enables.
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9
) ();

    logic                  m_req;
    logic                  m_we;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [BE_W-1:0]       m_be;
    logic [31:0]           m_wdata;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [31:0]           m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_be, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_be, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] m_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half lane ignores addr_lo[0], so an unaligned half reads the aligned-down half.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = addr_lo[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (addr_lo)
            2'b00:   byte_sel = m_rdata[7:0];
            2'b01:   byte_sel = m_rdata[15:8];
            2'b10:   byte_sel = m_rdata[23:16];
            default: byte_sel = m_rdata[31:24];
        endcase
    end

    always_comb begin
        ext_data = m_rdata;
        case (func3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'h000000, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'h0000, half_sel};
            default: ext_data = m_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: stalls the pipeline across a req/gnt/rvalid memory access.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign,
`endif
    load_store_unit_if.master     mem
);

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    lsu_state_t            state;
    lsu_state_t            state_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  we_q;
    logic [2:0]            func3_q;
    logic [1:0]            lane_q;
    logic                  err_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rd_q;
    logic [DATA_W-1:0]     load_ext;

    logic accept;
    logic in_flight;
    logic timeout;
    logic complete;
    logic trap;

    assign accept    = (state == IDLE) && (mem_read || mem_write);
    assign in_flight = (state == REQ) || (state == WAIT);
    assign timeout   = in_flight && (wait_cnt == CNT_MAX);
    assign complete  = (state == WAIT) && mem.m_rvalid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = accept && is_misaligned(func3[1:0], addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign mem.m_addr  = addr_q;
    assign mem.m_be    = be_q;
    assign mem.m_wdata = wdata_q;
    assign rd_data     = rd_q;

    load_extend u_load_extend (
        .m_rdata  (mem.m_rdata),
        .addr_lo  (lane_q),
        .func3    (func3_q),
        .ext_data (load_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A timed-out request is withdrawn in the same cycle the limit is hit, so a late gnt is not taken.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        bus_err    = 1'b0;
        mem.m_req  = 1'b0;
        mem.m_we   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign   = 1'b0;
`endif
        case (state)
            IDLE: begin
                stall = accept;
                if (trap) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (timeout) begin
                    state_next = DONE;
                end else begin
                    mem.m_req = 1'b1;
                    mem.m_we  = we_q;
                    if (mem.m_gnt) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (complete || timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                bus_err    = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign   = mis_q;
`endif
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; rd_q only moves when a load finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            we_q     <= 1'b0;
            func3_q  <= 3'b000;
            lane_q   <= 2'b00;
            err_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wait_cnt <= '0;
                we_q     <= mem_write;
                func3_q  <= func3;
                lane_q   <= addr[1:0];
                err_q    <= 1'b0;
                addr_q   <= {addr[DM_ADDRESS-1:2], 2'b00};
                be_q     <= byte_enables(func3[1:0], addr[1:0]);
                wdata_q  <= replicate_store(func3[1:0], wr_data);
                if (trap && !mem_write) begin
                    rd_q <= '0;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q    <= trap;
`endif
            end else if (complete) begin
                if (!we_q) begin
                    rd_q <= load_ext;
                end
            end else if (timeout) begin
                err_q <= 1'b1;
                if (!we_q) begin
                    rd_q <= '0;
                end
            end else if (in_flight && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses against a cycle-scripted memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  func3 = '0;
    logic        stall;
    logic        done;
    logic [31:0] rd_data;
    logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    load_store_unit_if #(.DM_ADDRESS(9)) ifc ();

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wr_data   (wr_data),
        .func3     (func3),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .bus_err   (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign  (misalign),
`endif
        .mem       (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
    } resp_exp_t;

    req_exp_t  req_q[$];
    resp_exp_t resp_q[$];
    int        total = 0;
    int        bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a granted request or a done pulse.
    always @(negedge clk) begin
        req_exp_t  rq;
        resp_exp_t rs;
        if (!reset) begin
            if (ifc.m_req && ifc.m_gnt) begin
                checkOutput("req_pending", 32'(req_q.size() != 0), 32'(1));
                if (req_q.size() != 0) begin
                    rq = req_q.pop_front();
                    checkOutput("m_addr", 32'(ifc.m_addr), 32'(rq.addr));
                    checkOutput("m_be", 32'(ifc.m_be), 32'(rq.be));
                    checkOutput("m_we", 32'(ifc.m_we), 32'(rq.we));
                    if (rq.we) checkOutput("m_wdata", ifc.m_wdata, rq.wdata);
                end
            end
            if (done) begin
                checkOutput("resp_pending", 32'(resp_q.size() != 0), 32'(1));
                if (resp_q.size() != 0) begin
                    rs = resp_q.pop_front();
                    checkOutput("rd_data", rd_data, rs.rd);
                    checkOutput("bus_err", 32'(bus_err), 32'(rs.err));
`ifdef LSU_MISALIGN_TRAP_EN
                    checkOutput("misalign", 32'(misalign), 32'(rs.mis));
`endif
                end
            end else begin
                checkOutput("bus_err_idle", 32'(bus_err), 32'(0));
            end
        end
    end

    // One access: memory grants in cycle gnt_cyc and holds rvalid from cycle rv_cyc on.
    task automatic applyStimulus(
        input logic wr, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
        input logic [31:0] rdata, input int gnt_cyc, input int rv_cyc,
        input logic [8:0] exp_maddr, input logic [3:0] exp_be, input logic [31:0] exp_wd,
        input logic [31:0] exp_rd, input logic exp_err, input logic exp_mis,
        input int exp_stall, input int exp_req);
        int   stall_n;
        int   req_n;
        int   done_k;
        logic seen;
        stall_n = 0;
        req_n   = 0;
        done_k  = -1;
        seen    = 1'b0;
        if (exp_req > 0 && gnt_cyc <= exp_req)
            req_q.push_back('{addr: exp_maddr, be: exp_be, we: wr, wdata: exp_wd});
        resp_q.push_back('{rd: exp_rd, err: exp_err, mis: exp_mis});
        @(posedge clk); #1;
        mem_write = wr;
        mem_read  = !wr;
        func3     = f3;
        addr      = a;
        wr_data   = wd;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            ifc.m_gnt    = (k == gnt_cyc);
            ifc.m_rvalid = (k >= rv_cyc);
            ifc.m_rdata  = rdata;
            @(negedge clk);
            if (stall) stall_n++;
            if (ifc.m_req) req_n++;
            if (done) begin
                seen   = 1'b1;
                done_k = k;
            end
        end
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ifc.m_gnt    = 1'b0;
        ifc.m_rvalid = 1'b0;
        checkOutput("done_seen", 32'(seen), 32'(1));
        checkOutput("done_cycle", 32'(done_k), 32'(exp_stall));
        checkOutput("stall_cycles", 32'(stall_n), 32'(exp_stall));
        checkOutput("req_cycles", 32'(req_n), 32'(exp_req));
    endtask

    initial begin
        ifc.m_gnt    = 1'b0;
        ifc.m_rvalid = 1'b0;
        ifc.m_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_req", 32'(ifc.m_req), 32'(0));
        checkOutput("rst_m_we", 32'(ifc.m_we), 32'(0));
        checkOutput("rst_m_be", 32'(ifc.m_be), 32'(0));
        checkOutput("rst_m_addr", 32'(ifc.m_addr), 32'(0));
        checkOutput("rst_m_wdata", ifc.m_wdata, 32'h0);
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_bus_err", 32'(bus_err), 32'(0));
        checkOutput("rst_rd_data", rd_data, 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        //            wr    f3     addr    wdata         rdata         gnt rv  maddr   be    exp_wd        exp_rd        err  mis  stl req
        applyStimulus(1'b1, F3_W,  9'h010, 32'hDEADBEEF, 32'h00000000, 1,  2,  9'h010, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_B,  9'h013, 32'h0,        32'h80FFFF7F, 1,  2,  9'h010, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_BU, 9'h013, 32'h0,        32'h80FFFF7F, 3,  1,  9'h010, 4'h8, 32'h0,        32'h00000080, 1'b0, 1'b0, 5, 3);
        applyStimulus(1'b0, F3_B,  9'h010, 32'h0,        32'h80FFFF7F, 1,  2,  9'h010, 4'h1, 32'h0,        32'h0000007F, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b1, F3_H,  9'h006, 32'h1234ABCD, 32'h00000000, 2,  5,  9'h004, 4'hC, 32'hABCDABCD, 32'h0000007F, 1'b0, 1'b0, 6, 2);
        applyStimulus(1'b0, F3_HU, 9'h006, 32'h0,        32'hABCD1234, 1,  2,  9'h004, 4'hC, 32'h0,        32'h0000ABCD, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_H,  9'h002, 32'h0,        32'h80015555, 1,  2,  9'h000, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b1, F3_B,  9'h011, 32'h000000A5, 32'h00000000, 1,  2,  9'h010, 4'h2, 32'hA5A5A5A5, 32'hFFFF8001, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_W,  9'h008, 32'h0,        32'h12345678, 1,  2,  9'h008, 4'hF, 32'h0,        32'h12345678, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_W,  9'h00C, 32'h0,        32'hFFFFFFFF, 99, 99, 9'h00C, 4'hF, 32'h0,        32'h00000000, 1'b1, 1'b0, 17, 15);
        applyStimulus(1'b0, 3'b011, 9'h014, 32'h0,       32'hCAFEF00D, 1,  2,  9'h014, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 3, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, F3_W,  9'h005, 32'h0,        32'h11223344, 1,  2,  9'h004, 4'hF, 32'h0,        32'h00000000, 1'b0, 1'b1, 1, 0);
        applyStimulus(1'b1, F3_H,  9'h007, 32'h5A5A5A5A, 32'h00000000, 1,  2,  9'h004, 4'hC, 32'h5A5A5A5A, 32'h00000000, 1'b0, 1'b1, 1, 0);
`else
        applyStimulus(1'b0, F3_W,  9'h005, 32'h0,        32'h11223344, 1,  2,  9'h004, 4'hF, 32'h0,        32'h11223344, 1'b0, 1'b0, 3, 1);
        applyStimulus(1'b0, F3_H,  9'h007, 32'h0,        32'hBEEF0000, 1,  2,  9'h004, 4'hC, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 3, 1);
`endif

        // Reset while waiting for rvalid: the access is abandoned and a late rvalid must not complete it.
        req_q.push_back('{addr: 9'h020, be: 4'hF, we: 1'b0, wdata: 32'h0});
        @(posedge clk); #1;
        mem_read = 1'b1;
        func3    = F3_W;
        addr     = 9'h020;
        @(posedge clk); #1;
        ifc.m_gnt = 1'b1;
        @(posedge clk); #1;
        ifc.m_gnt = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        checkOutput("wait_stall", 32'(stall), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_m_req", 32'(ifc.m_req), 32'(0));
        checkOutput("post_rst_stall", 32'(stall), 32'(0));
        checkOutput("post_rst_done", 32'(done), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ifc.m_rvalid = 1'b1;
            ifc.m_rdata  = 32'hFFFFFFFF;
            @(negedge clk);
            checkOutput("late_rvalid_done", 32'(done), 32'(0));
            checkOutput("late_rvalid_rd", rd_data, 32'h0);
        end
        @(posedge clk); #1;
        ifc.m_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("req_q_drained", 32'(req_q.size()), 32'(0));
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
